// File: rtl/vga_pkg.sv
// Shared VGA colour definitions: 12-bit {r,g,b} colour type, named colours
// and the default tile palette.
package vga_pkg;

   typedef logic [11:0] color_t;

   localparam color_t COLOR_RED    = 12'hF00;
   localparam color_t COLOR_GREEN  = 12'h0F0;
   localparam color_t COLOR_BLUE   = 12'h00F;
   localparam color_t COLOR_YELLOW = 12'hFF0;
   localparam color_t COLOR_WHITE  = 12'hFFF;
   localparam color_t COLOR_BLACK  = 12'h000;

   // Palette repeats every four tiles, keyed on the low index bits.
   function automatic color_t default_color(input logic [1:0] idx_lsb);
      color_t c;
      case (idx_lsb)
         2'd0:    c = COLOR_RED;
         2'd1:    c = COLOR_GREEN;
         2'd2:    c = COLOR_BLUE;
         2'd3:    c = COLOR_YELLOW;
         default: c = COLOR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/grid_block_renderer_if.sv
// Colour-table write port: valid/ready handshake carrying a tile index and colour.
interface grid_block_renderer_if #(
   parameter int IDX_W = 2
);
   import vga_pkg::*;

   logic             wr_valid;
   logic             wr_ready;
   logic [IDX_W-1:0] wr_index;
   color_t           wr_color;

   modport master (output wr_valid, output wr_index, output wr_color, input wr_ready);
   modport slave  (input wr_valid, input wr_index, input wr_color, output wr_ready);

endinterface

// File: rtl/tile_color_table.sv
// Register-file colour table with one write port (immediate or frame-synchronised
// through a one-entry holding register) and one combinational read port.
module tile_color_table
   import vga_pkg::*;
#(
   parameter int N           = 4,
   parameter int IDX_W       = 2,
   parameter int SYNC_WRITES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_frame_tick,
   input  logic             i_wr_valid,
   input  logic [IDX_W-1:0] i_wr_index,
   input  color_t           i_wr_color,
   output logic             o_wr_ready,
   input  logic [IDX_W-1:0] i_rd_index,
   output color_t           o_rd_color
);

   localparam logic [31:0] N_U = 32'(N);

   color_t           r_table [N];
   logic             r_pend;
   logic             r_ready;
   logic [IDX_W-1:0] r_hold_idx;
   color_t           r_hold_color;

   logic             w_accept;
   logic             w_do_write;
   logic             w_in_range;
   logic             w_pend_next;
   logic [IDX_W-1:0] w_wr_idx;
   color_t           w_wr_color;

   always_comb begin
      w_accept    = i_wr_valid & r_ready;
      w_do_write  = 1'b0;
      w_pend_next = 1'b0;
      w_wr_idx    = i_wr_index;
      w_wr_color  = i_wr_color;
      if (SYNC_WRITES != 0) begin
         // Held entry lands on frame_tick; a write taken on that same tick waits a frame.
         w_wr_idx    = r_hold_idx;
         w_wr_color  = r_hold_color;
         w_do_write  = r_pend & i_frame_tick;
         w_pend_next = w_accept | (r_pend & ~i_frame_tick);
      end else begin
         w_do_write  = w_accept;
         w_pend_next = 1'b0;
      end
      w_in_range = (32'(w_wr_idx) < N_U);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend       <= 1'b0;
         r_ready      <= 1'b0;
         r_hold_idx   <= '0;
         r_hold_color <= COLOR_BLACK;
      end else begin
         r_pend  <= w_pend_next;
         r_ready <= ~w_pend_next;
         if (w_accept) begin
            r_hold_idx   <= i_wr_index;
            r_hold_color <= i_wr_color;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            r_table[i] <= default_color(2'(i));
         end
      end else if (w_do_write && w_in_range) begin
         r_table[w_wr_idx] <= w_wr_color;
      end
   end

   assign o_wr_ready = r_ready;
   assign o_rd_color = (32'(i_rd_index) < N_U) ? r_table[i_rd_index] : COLOR_BLACK;

endmodule

// File: rtl/grid_block_renderer.sv
// Renders a ROWS x COLS grid of square tiles from a writable colour table onto
// the VGA pixel stream, with a blinking highlight tile; two-cycle latency.
module grid_block_renderer
   import vga_pkg::*;
#(
   parameter int     ORIGIN_X     = 100,
   parameter int     ORIGIN_Y     = 50,
   parameter int     TILE_LOG2    = 6,
   parameter int     COLS         = 2,
   parameter int     ROWS         = 2,
   parameter color_t BG_COLOR     = 12'hFFF,
   parameter int     BLINK_FRAMES = 30,
   parameter int     SYNC_WRITES  = 1,
   localparam int    NTILES       = COLS * ROWS,
   localparam int    IDX_W        = (NTILES > 1) ? $clog2(NTILES) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           x,
   input  logic [9:0]           y,
   input  logic                 active,
   input  logic                 frame_tick,
   grid_block_renderer_if.slave wr_if,
   input  logic                 sel_en,
   input  logic [IDX_W-1:0]     sel_index,
   output logic [3:0]           red,
   output logic [3:0]           green,
   output logic [3:0]           blue,
   output logic                 de
);

   // 11-bit bounds so a grid reaching past column/row 1023 cannot wrap.
   localparam logic [10:0] X_LO = 11'(ORIGIN_X);
   localparam logic [10:0] X_HI = 11'(ORIGIN_X + (COLS << TILE_LOG2));
   localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
   localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (ROWS << TILE_LOG2));
   localparam int          CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [10:0]      w_x;
   logic [10:0]      w_y;
   logic [10:0]      w_col;
   logic [10:0]      w_row;
   logic             w_in_grid;
   logic             w_hl;
   logic [IDX_W-1:0] w_index;
   color_t           w_tbl_color;
   color_t           w_color;

   logic             r_s1_active;
   logic             r_s1_in_grid;
   logic             r_s1_hl;
   logic [IDX_W-1:0] r_s1_index;
   logic [CNT_W-1:0] r_blink_cnt;
   logic             r_phase;

   tile_color_table #(
      .N           (NTILES),
      .IDX_W       (IDX_W),
      .SYNC_WRITES (SYNC_WRITES)
   ) u_table (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_tick (frame_tick),
      .i_wr_valid   (wr_if.wr_valid),
      .i_wr_index   (wr_if.wr_index),
      .i_wr_color   (wr_if.wr_color),
      .o_wr_ready   (wr_if.wr_ready),
      .i_rd_index   (r_s1_index),
      .o_rd_color   (w_tbl_color)
   );

   always_comb begin
      w_x       = {1'b0, x};
      w_y       = {1'b0, y};
      w_in_grid = (w_x >= X_LO) && (w_x < X_HI) && (w_y >= Y_LO) && (w_y < Y_HI);
      w_col     = (w_x - X_LO) >> TILE_LOG2;
      w_row     = (w_y - Y_LO) >> TILE_LOG2;
      w_index   = IDX_W'(w_row * 11'(COLS) + w_col);
      w_hl      = sel_en && (sel_index == w_index);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_active  <= 1'b0;
         r_s1_in_grid <= 1'b0;
         r_s1_hl      <= 1'b0;
         r_s1_index   <= '0;
      end else begin
         r_s1_active  <= active;
         r_s1_in_grid <= w_in_grid;
         r_s1_hl      <= w_hl;
         r_s1_index   <= w_index;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (frame_tick) begin
         if (r_blink_cnt == CNT_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_color = COLOR_BLACK;
      if (!r_s1_active) begin
         w_color = COLOR_BLACK;
      end else if (!r_s1_in_grid) begin
         w_color = BG_COLOR;
      end else if (r_s1_hl && r_phase) begin
         w_color = w_tbl_color ^ COLOR_WHITE;
      end else begin
         w_color = w_tbl_color;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         red   <= 4'h0;
         green <= 4'h0;
         blue  <= 4'h0;
         de    <= 1'b0;
      end else begin
         red   <= w_color[11:8];
         green <= w_color[7:4];
         blue  <= w_color[3:0];
         de    <= r_s1_active;
      end
   end

endmodule

// File: tb/tb_grid_block_renderer.sv
// Bench for grid_block_renderer: a 3x3 frame-synchronised instance and a 2x2
// immediate-write instance share one pixel stream and are checked every cycle.
module tb_grid_block_renderer;
   import vga_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] x;
   logic [9:0] y;
   logic       active;
   logic       frame_tick;
   logic       sel_en;
   logic [3:0] sel0;
   logic [1:0] sel1;
   logic [3:0] red0, green0, blue0, red1, green1, blue1;
   logic       de0, de1;

   int n_tests = 0;
   int n_fail  = 0;

   grid_block_renderer_if #(.IDX_W(4)) wif0 ();
   grid_block_renderer_if #(.IDX_W(2)) wif1 ();

   grid_block_renderer #(.COLS(3), .ROWS(3), .BLINK_FRAMES(2), .SYNC_WRITES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active), .frame_tick(frame_tick),
      .wr_if(wif0), .sel_en(sel_en), .sel_index(sel0),
      .red(red0), .green(green0), .blue(blue0), .de(de0)
   );

   grid_block_renderer #(.COLS(2), .ROWS(2), .BLINK_FRAMES(30), .SYNC_WRITES(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active), .frame_tick(frame_tick),
      .wr_if(wif1), .sel_en(sel_en), .sel_index(sel1),
      .red(red1), .green(green1), .blue(blue1), .de(de1)
   );

   always #5 clk = ~clk;

   // Reference model state, one slot per instance.
   int m_cols[2]  = '{3, 2};
   int m_rows[2]  = '{3, 2};
   int m_sync[2]  = '{1, 0};
   int m_blink[2] = '{2, 30};
   int m_tbl[2][16];
   int m_pend[2], m_hold_idx[2], m_hold_col[2], m_ready[2], m_cnt[2], m_phase[2];
   int p_x, p_y, p_act = 0, p_sel_en, p_sel[2];

   int xs[10] = '{0, 99, 100, 163, 164, 227, 228, 291, 292, 1023};
   int ys[10] = '{0, 49, 50, 113, 114, 177, 178, 241, 242, 1023};
   int lx[9]  = '{120, 170, 10, 163, 164, 228, 99, 120, 120};
   int ly[9]  = '{60, 120, 10, 60, 60, 60, 60, 177, 178};
   int lc[9]  = '{32'hF00, 32'hFF0, 32'hFFF, 32'hF00, 32'h0F0, 32'hFFF, 32'hFFF, 32'h00F, 32'hFFF};

   task automatic check_value(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic int palette(input int i);
      case (i % 4)
         0:       return 32'hF00;
         1:       return 32'h0F0;
         2:       return 32'h00F;
         default: return 32'hFF0;
      endcase
   endfunction

   // Expected {de,r,g,b} for the pixel presented one cycle earlier.
   function automatic int exp_pixel(input int d);
      int c;
      int idx;
      if (p_act == 0) return 0;
      if (p_x >= 100 && p_x < 100 + m_cols[d] * 64 && p_y >= 50 && p_y < 50 + m_rows[d] * 64) begin
         idx = ((p_y - 50) / 64) * m_cols[d] + (p_x - 100) / 64;
         c = m_tbl[d][idx];
         if (p_sel_en != 0 && p_sel[d] == idx && m_phase[d] != 0) c = c ^ 32'hFFF;
      end else begin
         c = 32'hFFF;
      end
      return 32'h1000 | c;
   endfunction

   function automatic void model_update(input int d, input int wv, input int wi, input int wc);
      int n;
      n = m_cols[d] * m_rows[d];
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) m_tbl[d][i] = palette(i);
         m_pend[d] = 0; m_ready[d] = 0; m_cnt[d] = 0; m_phase[d] = 0;
      end else begin
         if (m_sync[d] != 0) begin
            if (frame_tick && m_pend[d] != 0) begin
               if (m_hold_idx[d] < n) m_tbl[d][m_hold_idx[d]] = m_hold_col[d];
               m_pend[d] = 0;
            end
            if (wv != 0 && m_ready[d] != 0) begin
               m_hold_idx[d] = wi; m_hold_col[d] = wc; m_pend[d] = 1;
            end
            m_ready[d] = (m_pend[d] == 0) ? 1 : 0;
         end else begin
            if (wv != 0 && m_ready[d] != 0 && wi < n) m_tbl[d][wi] = wc;
            m_ready[d] = 1;
         end
         if (frame_tick) begin
            if (m_cnt[d] == m_blink[d] - 1) begin
               m_cnt[d] = 0;
               m_phase[d] ^= 1;
            end else begin
               m_cnt[d]++;
            end
         end
      end
   endfunction

   task automatic tick();
      int e[2];
      for (int d = 0; d < 2; d++) e[d] = rst_n ? exp_pixel(d) : 0;
      model_update(0, int'(wif0.wr_valid), int'(wif0.wr_index), int'(wif0.wr_color));
      model_update(1, int'(wif1.wr_valid), int'(wif1.wr_index), int'(wif1.wr_color));
      if (!rst_n) begin
         p_act = 0;
      end else begin
         p_x = int'(x); p_y = int'(y); p_act = int'(active);
         p_sel_en = int'(sel_en); p_sel[0] = int'(sel0); p_sel[1] = int'(sel1);
      end
      @(posedge clk);
      #1;
      check_value("pix0", int'({de0, red0, green0, blue0}), e[0]);
      check_value("pix1", int'({de1, red1, green1, blue1}), e[1]);
      check_value("rdy0", int'(wif0.wr_ready), m_ready[0]);
      check_value("rdy1", int'(wif1.wr_ready), m_ready[1]);
   endtask

   task automatic drive(input int px, input int py, input logic act);
      x = 10'(px); y = 10'(py); active = act;
   endtask

   task automatic frame_pulse();
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
   endtask

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; sel_en = 1'b0; sel0 = 4'd0; sel1 = 2'd0;
      drive(0, 0, 1'b0);
      wif0.wr_valid = 1'b0; wif0.wr_index = 4'd0; wif0.wr_color = 12'h000;
      wif1.wr_valid = 1'b0; wif1.wr_index = 2'd0; wif1.wr_color = 12'h000;
      repeat (3) tick();
      check_value("rst_rgb", int'({de0, red0, green0, blue0}), 0);
      check_value("rst_rdy", int'(wif0.wr_ready), 0);
      rst_n = 1'b1;

      // Default palette and grid boundaries on the 2x2 instance.
      for (int i = 0; i < 9; i++) begin
         drive(lx[i], ly[i], 1'b1);
         tick(); tick();
         check_value("lit_pix", int'({red1, green1, blue1}), lc[i]);
      end
      drive(120, 60, 1'b0);
      tick(); tick();
      check_value("lit_blank", int'({de1, red1, green1, blue1}), 0);

      // Frame-synchronised write on the 3x3 instance (tile 3 at 120,120).
      drive(120, 120, 1'b1);
      wif0.wr_valid = 1'b1; wif0.wr_index = 4'd3; wif0.wr_color = 12'h0AB;
      tick();
      wif0.wr_valid = 1'b0;
      check_value("lit_rdy_low", int'(wif0.wr_ready), 0);
      tick(); tick();
      check_value("lit_held", int'({red0, green0, blue0}), 32'hFF0);
      frame_pulse();
      check_value("lit_rdy_back", int'(wif0.wr_ready), 1);
      tick();
      check_value("lit_commit", int'({red0, green0, blue0}), 32'h0AB);
      wif0.wr_valid = 1'b1; wif0.wr_index = 4'd12; wif0.wr_color = 12'h123;
      tick();
      wif0.wr_valid = 1'b0;
      frame_pulse(); tick();
      check_value("lit_oor", int'({red0, green0, blue0}), 32'h0AB);
      wif0.wr_valid = 1'b1; wif0.wr_index = 4'd3; wif0.wr_color = 12'h555; frame_tick = 1'b1;
      tick();
      wif0.wr_valid = 1'b0; frame_tick = 1'b0;
      tick(); tick();
      check_value("lit_same_tick", int'({red0, green0, blue0}), 32'h0AB);
      frame_pulse(); tick();
      check_value("lit_next_tick", int'({red0, green0, blue0}), 32'h555);

      // Immediate write on the 2x2 instance: read-before-write on the handshake edge.
      drive(170, 60, 1'b1);
      tick(); tick();
      wif1.wr_valid = 1'b1; wif1.wr_index = 2'd1; wif1.wr_color = 12'h123;
      tick();
      wif1.wr_valid = 1'b0;
      check_value("lit_rbw_old", int'({red1, green1, blue1}), 32'h0F0);
      tick();
      check_value("lit_rbw_new", int'({red1, green1, blue1}), 32'h123);

      // Blink on tile 0 of the 3x3 instance (two frames per half-period).
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      sel_en = 1'b1; sel0 = 4'd0; sel1 = 2'd0;
      drive(120, 60, 1'b1);
      tick(); tick();
      for (int c = 1; c <= 6; c++) begin
         frame_pulse(); tick();
         check_value("lit_blink", int'({red0, green0, blue0}), (((c / 2) % 2) != 0) ? 32'h0FF : 32'hF00);
      end
      sel0 = 4'd12;
      tick(); tick();
      check_value("lit_no_sel", int'({red0, green0, blue0}), 32'hF00);

      // Reset with a pending write and blink phase set.
      sel0 = 4'd0;
      wif0.wr_valid = 1'b1; wif0.wr_index = 4'd0; wif0.wr_color = 12'h0AB;
      tick();
      wif0.wr_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      check_value("lit_rst_pix", int'({de0, red0, green0, blue0, de1, red1, green1, blue1}), 0);
      check_value("lit_rst_rdy", int'({wif0.wr_ready, wif1.wr_ready}), 0);
      rst_n = 1'b1;
      for (int f = 0; f < 29; f++) frame_pulse();
      tick();
      check_value("lit_29_frames", int'({red1, green1, blue1}), 32'hF00);
      frame_pulse(); tick();
      check_value("lit_30_frames", int'({red1, green1, blue1}), 32'h0FF);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         x = ($urandom_range(0, 1) != 0) ? 10'(xs[$urandom_range(0, 9)]) : 10'($urandom);
         y = ($urandom_range(0, 1) != 0) ? 10'(ys[$urandom_range(0, 9)]) : 10'($urandom);
         active     = ($urandom_range(0, 7) != 0);
         frame_tick = ($urandom_range(0, 15) == 0);
         sel_en     = ($urandom_range(0, 1) != 0);
         sel0       = 4'($urandom);
         sel1       = 2'($urandom);
         wif0.wr_valid = ($urandom_range(0, 3) == 0);
         wif0.wr_index = 4'($urandom);
         wif0.wr_color = 12'($urandom);
         wif1.wr_valid = ($urandom_range(0, 3) == 0);
         wif1.wr_index = 2'($urandom);
         wif1.wr_color = 12'($urandom);
         rst_n = ($urandom_range(0, 599) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/grid_block_renderer.md
Name: grid_block_renderer

Overview:
Parametrised, pipelined successor to the fixed 2x2 colour-block generator. Maps the VGA pixel coordinate onto a ROWS x COLS grid of square tiles and outputs each tile's colour from a writable colour table. Adds a blinking highlight on one selected tile and frame-synchronised colour updates. Sits between the VGA sync counter (x, y, active video) and the RGB output pins.

Parameters:
ORIGIN_X, 100, left pixel column of the grid
ORIGIN_Y, 50, top pixel row of the grid
TILE_LOG2, 6, tile edge = 2**TILE_LOG2 pixels (64)
COLS, 2, tiles per row (1..16)
ROWS, 2, tiles per column (1..16)
BG_COLOR, 12'hFFF, {r,g,b} colour outside the grid
BLINK_FRAMES, 30, frames per blink half-period (>=1)
SYNC_WRITES, 1, 1 = colour writes are held until frame_tick; 0 = applied immediately

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous reset, active-low
x  in  10  current pixel column
y  in  10  current pixel row
active  in  1  pixel is in the visible area
frame_tick  in  1  one-cycle pulse, once per frame (start of vertical blank)
wr_valid  in  1  colour write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_index  in  IDX_W  tile index = row*COLS+col; IDX_W = max(1, clog2(COLS*ROWS))
wr_color  in  12  {r[3:0],g[3:0],b[3:0]}
sel_en  in  1  highlight enable
sel_index  in  IDX_W  tile to highlight
red  out  4  registered colour
green  out  4
blue  out  4
de  out  1  active, delayed to match the RGB outputs

Behaviour:
- Reset (rst_n=0 at a clk edge): red/green/blue=0, de=0, wr_ready=0, pending write cleared, blink counter=0, blink phase=0. The colour table is loaded with index mod 4 -> F00, 0F0, 00F, FF0.
- wr_ready is asserted from the first cycle after reset is released.
- Pipeline latency is 2 cycles, fully pipelined with 1 pixel per clock.
  - Stage 1 registers active, in_grid and index.
  - Stage 2 registers the RGB outputs and de.
- in_grid: ORIGIN_X <= x < ORIGIN_X + (COLS<<TILE_LOG2), and likewise for y with ROWS.
  - col = (x-ORIGIN_X)>>TILE_LOG2; row = (y-ORIGIN_Y)>>TILE_LOG2.
  - Comparisons use 11-bit unsigned arithmetic, so a grid extending past 1023 does not wrap.
- Stage 2 colour selection:
  - !active -> 000.
  - active & !in_grid -> BG_COLOR.
  - in_grid -> table[index].
  - If additionally sel_en & sel_index==index & blink phase=1, the output is table[index] XOR FFF.
  - sel_en and sel_index are sampled in stage 1.
- Blink:
  - On frame_tick the counter increments.
  - When the counter equals BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
  - The counter runs regardless of sel_en.
- Writes with SYNC_WRITES=0:
  - An accepted write updates the table at the clk edge of the handshake.
  - A stage-2 read of the same index in that cycle returns the old value (read-before-write).
  - wr_ready stays 1.
- Writes with SYNC_WRITES=1 (one-entry holding register):
  - An accepted write is stored and wr_ready drops to 0 the next cycle.
  - On the next frame_tick the held entry is committed to the table and wr_ready returns to 1 the following cycle.
  - A write accepted in the same cycle as a frame_tick is held until the following frame_tick; it is not committed immediately.
- wr_index >= COLS*ROWS: the handshake completes normally and the table is not changed.
- sel_index >= COLS*ROWS: no tile is highlighted.
- Reset mid-frame or with a pending write: the pending write is discarded and the table is restored to its defaults.

Decomposition:
- Shared package (vga_pkg):
  - 12-bit colour typedef.
  - Constants COLOR_RED=F00, COLOR_GREEN=0F0, COLOR_BLUE=00F, COLOR_YELLOW=FF0, COLOR_WHITE=FFF, COLOR_BLACK=000.
  - The default-palette function.
- One sub-module: tile_color_table (register-file colour table with the sync/async write port and the holding register).
- Coordinate mapping, blink logic and the output pipeline stay in the top module.

Test Plan:
- Defaults: after reset, drive x=120,y=60,active=1 -> red=F,green=0,blue=0 two cycles later. x=170,y=120 -> yellow (FF0). x=10,y=10 -> FFF. active=0 -> 000 and de=0.
- Boundaries: x=163 -> tile 0 colour; x=164 -> tile 1 colour; x=228,y=60 -> BG; x=99 -> BG; y=177 vs y=178 checked the same way. Latency is exactly 2 cycles on every sample.
- SYNC_WRITES=1: write index 2, colour 0AB -> wr_ready=0 the next cycle and pixel x=120,y=120 still shows 00F. After frame_tick it shows 0AB and wr_ready=1. A write of index 7 -> handshake completes, no visible change.
- SYNC_WRITES=0: write index 1, colour 123 -> pixel x=170,y=60 shows 123 from the next sampled pixel onward. A same-cycle read of index 1 shows the old colour 0F0.
- Blink (BLINK_FRAMES=2): sel_en=1, sel_index=0 -> tile 0 reads F00 for 2 frame_ticks, then 0FF for 2, then F00 again. sel_index=5 -> never inverted.
- Reset mid-operation: rst_n=0 with a write pending and blink phase=1 -> all outputs 0, wr_ready=0, and after release the default palette is restored with no highlight until 30 frames have elapsed.
